// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 1:8 TDM demultiplexer.
package demux_pkg;

  localparam int unsigned NCH    = 8;
  localparam int unsigned SLOT_W = 3;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

endpackage

// File: rtl/demux_slot_tracker.sv
// Frame-sync slot tracker: HUNT/LOCKED FSM, slot counter, lock flag and sync-error pulse.
module demux_slot_tracker
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [SLOT_W-1:0] slot,
  output logic              wr_en,
  output logic              locked,
  output logic              sync_err
);

  state_t              state, state_nxt, cur_state;
  logic [SLOT_W-1:0]   slot_q, slot_nxt, cur_slot;
  logic                mode_q;
  logic                mode_chg;
  logic                err_nxt;

  // A mode change restarts the tracker, yet the same-cycle sample is still
  // processed: evaluate it against a freshly reset state/slot.
  assign mode_chg  = (mode != mode_q);
  assign cur_state = mode_chg ? HUNT : state;
  assign cur_slot  = mode_chg ? '0 : slot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      slot_q   <= '0;
      mode_q   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      slot_q   <= slot_nxt;
      mode_q   <= mode;
      sync_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = cur_state;
    slot_nxt  = cur_slot;
    err_nxt   = 1'b0;
    if (!mode) begin
      state_nxt = HUNT;
      slot_nxt  = '0;
    end else if (din_valid) begin
      if (frame_sync) begin
        state_nxt = LOCKED;
        slot_nxt  = SLOT_W'(1);
        err_nxt   = (cur_state == LOCKED) && (cur_slot != '0);
      end else if (cur_state == LOCKED) begin
        slot_nxt  = cur_slot + SLOT_W'(1);
      end
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    slot   = cur_slot;
    locked = (state == LOCKED);
    if (mode && din_valid) begin
      if (frame_sync) begin
        wr_en = 1'b1;
        slot  = '0;
      end else if (cur_state == LOCKED) begin
        wr_en = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux1x8_tdm.sv
// Registered 1:8 time-division demultiplexer with direct or frame-sync-driven slot selection.
module demux1x8_tdm
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  input  logic [2:0]           sel,
  output logic [8*WIDTH-1:0]   y,
  output logic [7:0]           ch_valid,
  output logic                 frame_done,
  output logic                 sync_err,
  output logic                 locked
);

  logic [SLOT_W-1:0] auto_slot;
  logic              auto_wr;
  logic [SLOT_W-1:0] idx;
  logic              wr;

  demux_slot_tracker u_tracker (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .slot       (auto_slot),
    .wr_en      (auto_wr),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  assign idx = mode ? auto_slot : sel;
  assign wr  = mode ? auto_wr   : din_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      y          <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
    end else begin
      ch_valid   <= wr ? (8'b1 << idx) : '0;
      frame_done <= wr && (idx == SLOT_W'(NCH - 1));
      for (int unsigned k = 0; k < NCH; k++) begin
        if (wr && (idx == k[SLOT_W-1:0])) begin
          y[k*WIDTH +: WIDTH] <= din;
        end
      end
    end
  end

endmodule
